// File: rtl/fifo_flow_ctrl.sv
// Per-virtual-channel synchronous FIFO with occupancy count, threshold flow-control
// status and sticky overflow/underflow error flags.
module fifo_flow_ctrl #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned ADDR_SIZE = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE:0]   afull_thr,
  input  logic [ADDR_SIZE:0]   aempty_thr,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic [ADDR_SIZE:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow_err,
  output logic                 underflow_err
);

  localparam int unsigned DEPTH = 1 << ADDR_SIZE;
  localparam int unsigned CW    = ADDR_SIZE + 1;

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic                 push_ok;
  logic                 pop_ok;

  // Status decoded from the registered count; count alone distinguishes full from empty.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= afull_thr);
  assign almost_empty = (count <= aempty_thr);

  // A full FIFO never takes a write in the cycle it frees a slot, and an empty one never
  // forwards a word pushed in the same cycle.
  assign push_ok = wr_en & ~full;
  assign pop_ok  = rd_en & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem           <= '{default: '0};
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      data_out      <= '0;
      valid_out     <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + ADDR_SIZE'(1);
      end

      valid_out <= pop_ok;
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + ADDR_SIZE'(1);
      end

      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (wr_en && full)  overflow_err  <= 1'b1;
      if (rd_en && empty) underflow_err <= 1'b1;
    end
  end

endmodule
